// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host receiver: synchronises and filters the keyboard lines, deserialises
// 11-bit frames and publishes the last two good bytes for the note display stage.
module ps2_scan_receiver #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan,
    output logic [7:0] prevscan,
    output logic       scan_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StData   = 2'd1;
    localparam logic [1:0] StParity = 2'd2;
    localparam logic [1:0] StStop   = 2'd3;

    logic [1:0]    clk_s_q, dat_s_q;
    logic          clk_f_q, clk_f_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall;
    logic          dat;

    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    scan_q, scan_d, prev_q, prev_d;
    logic          sv_q, sv_d, pe_q, pe_d, fe_q, fe_d;
    logic          par_ok;

    assign dat = dat_s_q[1];

    // The filtered clock only follows the line after FILTER_LEN disagreeing samples in a row.
    always_comb begin
        clk_f_d    = clk_f_q;
        filt_cnt_d = '0;
        if (clk_s_q[1] != clk_f_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                clk_f_d = clk_s_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign fall   = clk_f_q & ~clk_f_d;
    assign par_ok = ^{shreg_q, par_q};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        to_cnt_d  = to_cnt_q;
        scan_d    = scan_q;
        prev_d    = prev_q;
        sv_d      = 1'b0;
        pe_d      = 1'b0;
        fe_d      = 1'b0;
        if (fall) begin
            // A fall always beats a coincident timeout.
            to_cnt_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (!dat) begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                    end
                end
                StData: begin
                    shreg_d   = {dat, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    par_d   = dat;
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (par_ok && dat) begin
                        prev_d = scan_q;
                        scan_d = shreg_q;
                        sv_d   = 1'b1;
                    end else if (!par_ok) begin
                        pe_d = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q == StIdle) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
            state_d  = StIdle;
            to_cnt_d = '0;
            fe_d     = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            clk_s_q    <= 2'b11;
            dat_s_q    <= 2'b11;
            clk_f_q    <= 1'b1;
            filt_cnt_q <= '0;
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd0;
            shreg_q    <= 8'h00;
            par_q      <= 1'b0;
            to_cnt_q   <= '0;
            scan_q     <= 8'h00;
            prev_q     <= 8'h00;
            sv_q       <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            clk_s_q    <= {clk_s_q[0], ps2_clk};
            dat_s_q    <= {dat_s_q[0], ps2_data};
            clk_f_q    <= clk_f_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            to_cnt_q   <= to_cnt_d;
            scan_q     <= scan_d;
            prev_q     <= prev_d;
            sv_q       <= sv_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
        end
    end

    assign scan       = scan_q;
    assign prevscan   = prev_q;
    assign scan_valid = sv_q;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed and randomised frame bench for ps2_scan_receiver with a byte-level reference model.
module tb_ps2_scan_receiver;

    localparam int unsigned FILT = 8;
    localparam int unsigned TO   = 2000;
    localparam int unsigned HALF = 40;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b1;
    logic       ps2_clk    = 1'b1;
    logic       ps2_data   = 1'b1;
    logic [7:0] scan, prevscan;
    logic       scan_valid, parity_err, frame_err, busy;

    ps2_scan_receiver #(
        .FILTER_LEN  (FILT),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .scan       (scan),
        .prevscan   (prevscan),
        .scan_valid (scan_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, n_sv = 0, n_pe = 0, n_fe = 0, fe_cyc = 0, last_fall = 0;
    int b_sv, b_pe, b_fe;
    logic [7:0] exp_scan = 8'h00, exp_prev = 8'h00;

    // Pulse monitor: counts high cycles so a stretched pulse shows up as an extra count.
    always @(negedge clk_100MHz) begin
        cyc++;
        if (scan_valid) n_sv++;
        if (parity_err) n_pe++;
        if (frame_err) begin
            n_fe++;
            fe_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_100MHz);
        #1;
    endtask

    task automatic snap();
        b_sv = n_sv;
        b_pe = n_pe;
        b_fe = n_fe;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(HALF / 2);
        ps2_clk   = 1'b0;
        last_fall = cyc;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
        wait_cyc(HALF / 2);
    endtask

    task automatic expect_state(input string tag, input int esv, input int epe, input int efe);
        check({tag, ".sv"}, n_sv - b_sv, esv);
        check({tag, ".pe"}, n_pe - b_pe, epe);
        check({tag, ".fe"}, n_fe - b_fe, efe);
        check({tag, ".scan"}, scan, exp_scan);
        check({tag, ".prev"}, prevscan, exp_prev);
        check({tag, ".busy"}, busy, 1'b0);
    endtask

    // Sends one full frame and applies the byte-level outcome rules to the model.
    task automatic frame(input string tag, input logic [7:0] d, input logic bad_par,
                         input logic stop);
        logic p;
        int esv, epe, efe;
        p = ~(^d) ^ bad_par;
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(stop);
        ps2_data = 1'b1;
        wait_cyc(30);
        esv = 0; epe = 0; efe = 0;
        if (!bad_par && stop) begin
            exp_prev = exp_scan;
            exp_scan = d;
            esv = 1;
        end else if (bad_par) begin
            epe = 1;
        end else begin
            efe = 1;
        end
        expect_state(tag, esv, epe, efe);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        exp_scan = 8'h00;
        exp_prev = 8'h00;
        wait_cyc(2);
    endtask

    initial begin
        logic [7:0] rd;
        logic       rbad, rstop;
        int         sv0;

        // Reset state
        wait_cyc(4);
        reset = 1'b0;
        #1;
        check("rst.scan", scan, 8'h00);
        check("rst.prev", prevscan, 8'h00);
        check("rst.sv", scan_valid, 1'b0);
        check("rst.pe", parity_err, 1'b0);
        check("rst.fe", frame_err, 1'b0);
        check("rst.busy", busy, 1'b0);

        // Single good frame
        frame("f23", 8'h23, 1'b0, 1'b1);

        // Byte pair shifting, including the break prefix
        do_reset();
        sv0 = n_sv;
        frame("s12", 8'h12, 1'b0, 1'b1);
        frame("s23", 8'h23, 1'b0, 1'b1);
        frame("sF0", 8'hF0, 1'b0, 1'b1);
        frame("s23b", 8'h23, 1'b0, 1'b1);
        check("seq.count", n_sv - sv0, 4);

        // Parity error, then recovery
        frame("par", 8'h23, 1'b1, 1'b1);
        frame("par.1B", 8'h1B, 1'b0, 1'b1);

        // Stop bit error, and both bad (parity wins)
        frame("stop", 8'h23, 1'b0, 1'b0);
        frame("both", 8'h5A, 1'b1, 1'b0);

        // Timeout after start plus 4 data bits
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(rd_bit(8'h1B, i));
        check("to.busy_mid", busy, 1'b1);
        wait_cyc(TO + TO / 4);
        expect_state("to", 0, 0, 1);
        check("to.delay", (fe_cyc - last_fall >= TO) && (fe_cyc - last_fall <= TO + HALF), 1'b1);
        frame("to.1B", 8'h1B, 1'b0, 1'b1);

        // Short low glitch in idle
        snap();
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(4);
        check("gl.busy_in", busy, 1'b0);
        wait_cyc(20);
        expect_state("gl", 0, 0, 0);

        // Reset in the middle of a frame
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(rd_bit(8'hA5, i));
        check("mr.busy_mid", busy, 1'b1);
        snap();
        do_reset();
        expect_state("mr", 0, 0, 0);
        frame("mr.2D", 8'h2D, 1'b0, 1'b1);

        // Randomised frames
        for (int k = 0; k < 8; k++) begin
            rd    = 8'($urandom);
            rbad  = ($urandom_range(0, 3) == 0);
            rstop = ($urandom_range(0, 3) != 0);
            frame($sformatf("rnd%0d", k), rd, rbad, rstop);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    function automatic logic rd_bit(input logic [7:0] v, input int i);
        return v[i];
    endfunction

endmodule
